// File: rtl/output_wrapper_ctrl.sv
// Serialises one divide result per res_valid/res_ready handshake into NUM_BYTES bus bytes; first bus_valid 3 cycles after handshake.
// Backpressure: bus_valid holds until bus_ready, aborting with err after TIMEOUT stalled cycles; res_ready only while IDLE.
module output_wrapper_ctrl #(
    parameter int NUM_BYTES = 4,
    parameter int TIMEOUT   = 255,
    parameter int TO_W      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic res_valid,
    output logic res_ready,
    input  logic flush,
    output logic inz_cnt,
    output logic inc_cnt,
    output logic load_bus,
    input  logic cnt_co,
    output logic bus_valid,
    input  logic bus_ready,
    output logic busy,
    output logic frame_done,
    output logic err
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BYTES - 1);
    localparam logic [TO_W-1:0]  STALL_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit               TO_EN      = (TIMEOUT > 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_LOAD,
        ST_SHOW,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [TO_W-1:0]   stall_q, stall_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            stall_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        stall_d    = stall_q;
        err_d      = err_q;
        res_ready  = 1'b0;
        inz_cnt    = 1'b0;
        inc_cnt    = 1'b0;
        load_bus   = 1'b0;
        bus_valid  = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                inz_cnt    = 1'b1;
                byte_idx_d = '0;
                stall_d    = '0;
                state_d    = ST_LOAD;
            end
            ST_LOAD: begin
                load_bus = 1'b1;
                state_d  = ST_SHOW;
            end
            ST_SHOW: begin
                bus_valid = 1'b1;
                // An accept on the last allowed stall cycle wins over the timeout.
                if (bus_ready) begin
                    inc_cnt = 1'b1;
                    stall_d = '0;
                    if (byte_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        state_d    = ST_LOAD;
                    end
                end else if (TO_EN && (stall_q == STALL_LAST)) begin
                    err_d   = 1'b1;
                    stall_d = '0;
                    state_d = ST_IDLE;
                end else if (stall_q != '1) begin
                    stall_d = stall_q + TO_W'(1);
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                if (!cnt_co) begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush overrides everything, including a pending handshake in IDLE.
        if (flush) begin
            state_d    = ST_IDLE;
            inz_cnt    = 1'b1;
            inc_cnt    = 1'b0;
            load_bus   = 1'b0;
            frame_done = 1'b0;
            byte_idx_d = '0;
            stall_d    = '0;
            err_d      = 1'b0;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign err  = err_q;

endmodule

// File: tb/tb_output_wrapper_ctrl.sv
// Directed bench: instance 0 uses default TIMEOUT, instance 1 uses TIMEOUT=8; a small datapath model drives cnt_co and the bus byte.
module tb_output_wrapper_ctrl;

    localparam logic [2:0] Z  = 3'b000;
    localparam logic [2:0] B  = 3'b001;
    localparam logic [2:0] F  = 3'b010;
    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] RB = 3'b101;
    localparam logic [2:0] RF = 3'b110;

    logic clk;
    logic rst;
    logic res_valid  [2];
    logic flush      [2];
    logic bus_ready  [2];
    logic cnt_co     [2];
    logic res_ready  [2];
    logic inz_cnt    [2];
    logic inc_cnt    [2];
    logic load_bus   [2];
    logic bus_valid  [2];
    logic busy       [2];
    logic frame_done [2];
    logic err        [2];

    logic [15:0] q        [2];
    logic [15:0] r        [2];
    logic        force_co0[2];
    logic [2:0]  cnt      [2];
    logic [7:0]  bus_byte [2];

    logic [2:0]  tin  [$];
    logic [7:0]  texp [$];
    int          n_total;
    int          n_pass;

    output_wrapper_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .res_valid  (res_valid[0]),
        .res_ready  (res_ready[0]),
        .flush      (flush[0]),
        .inz_cnt    (inz_cnt[0]),
        .inc_cnt    (inc_cnt[0]),
        .load_bus   (load_bus[0]),
        .cnt_co     (cnt_co[0]),
        .bus_valid  (bus_valid[0]),
        .bus_ready  (bus_ready[0]),
        .busy       (busy[0]),
        .frame_done (frame_done[0]),
        .err        (err[0])
    );

    output_wrapper_ctrl #(.TIMEOUT(8)) u_dut_to8 (
        .clk        (clk),
        .rst        (rst),
        .res_valid  (res_valid[1]),
        .res_ready  (res_ready[1]),
        .flush      (flush[1]),
        .inz_cnt    (inz_cnt[1]),
        .inc_cnt    (inc_cnt[1]),
        .load_bus   (load_bus[1]),
        .cnt_co     (cnt_co[1]),
        .bus_valid  (bus_valid[1]),
        .bus_ready  (bus_ready[1]),
        .busy       (busy[1]),
        .frame_done (frame_done[1]),
        .err        (err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pick(input logic [15:0] qv, input logic [15:0] rv, input logic [1:0] idx);
        case (idx)
            2'd0:    return qv[15:8];
            2'd1:    return qv[7:0];
            2'd2:    return rv[15:8];
            default: return rv[7:0];
        endcase
    endfunction

    // Datapath model: byte counter with carry-out at NUM_BYTES, bus register loaded from the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                cnt[k]      <= 3'd0;
                bus_byte[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (inz_cnt[k]) cnt[k] <= 3'd0;
                else if (inc_cnt[k]) cnt[k] <= cnt[k] + 3'd1;
                if (load_bus[k]) bus_byte[k] <= pick(q[k], r[k], cnt[k][1:0]);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cnt_co[k] = !force_co0[k] && (cnt[k] == 3'd4);
        end
    end

    // {res_ready, inz_cnt, inc_cnt, load_bus, bus_valid, busy, frame_done, err}
    function automatic logic [7:0] outs(input int k);
        return {res_ready[k], inz_cnt[k], inc_cnt[k], load_bus[k],
                bus_valid[k], busy[k], frame_done[k], err[k]};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    // One table entry per cycle: apply {res_valid, flush, bus_ready}, then check outputs and the shown byte.
    task automatic run(input int k, input string tag);
        int bidx;
        bidx = 0;
        for (int c = 0; c < texp.size(); c++) begin
            @(negedge clk);
            res_valid[k] = tin[c][2];
            flush[k]     = tin[c][1];
            bus_ready[k] = tin[c][0];
            #1;
            chk($sformatf("%s_c%0d_outs", tag, c), outs(k), texp[c]);
            if (texp[c][6]) bidx = 0;
            if (texp[c][3]) chk($sformatf("%s_c%0d_byte", tag, c), bus_byte[k], pick(q[k], r[k], 2'(bidx)));
            if (texp[c][5]) bidx++;
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        for (int k = 0; k < 2; k++) begin
            res_valid[k] = 1'b0;
            flush[k]     = 1'b0;
            bus_ready[k] = 1'b0;
            force_co0[k] = 1'b0;
            q[k]         = 16'h0000;
            r[k]         = 16'h0000;
        end
        #1;
        chk("reset_dut0", outs(0), 8'h80);
        chk("reset_dut1", outs(1), 8'h80);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of SHOW
        q[0] = 16'h1234; r[0] = 16'h0056;
        tin  = '{R, Z, Z, Z};
        texp = '{8'h80, 8'h44, 8'h14, 8'h0C};
        run(0, "t1");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("t1_async_rst", outs(0), 8'h80);
        @(negedge clk);
        rst = 1'b0;

        // Clean full-speed frame
        tin  = '{RB, B, B, B, B, B, B, B, B, B, B, B};
        texp = '{8'h80, 8'h44, 8'h14, 8'h2C, 8'h14, 8'h2C, 8'h14, 8'h2C, 8'h14, 8'h2C, 8'h06, 8'h80};
        run(0, "t2");

        // Five stalled cycles on byte 2
        q[0] = 16'hA1B2; r[0] = 16'h00C3;
        tin  = '{RB, B, B, B, B, B, B, Z, Z, Z, Z, Z, B, B, B, B, B};
        texp = '{8'h80, 8'h44, 8'h14, 8'h2C, 8'h14, 8'h2C, 8'h14, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C,
                 8'h2C, 8'h14, 8'h2C, 8'h06, 8'h80};
        run(0, "t3");

        // Carry-out missing at DONE; res_valid during SHOW is ignored
        q[0] = 16'h8001; r[0] = 16'h7FFE;
        force_co0[0] = 1'b1;
        tin  = '{R, Z, Z, R, B, B, B, B, B, B, B, B, Z, Z};
        texp = '{8'h80, 8'h44, 8'h14, 8'h0C, 8'h2C, 8'h14, 8'h2C, 8'h14, 8'h2C, 8'h14, 8'h2C, 8'h06,
                 8'h81, 8'h81};
        run(0, "t6");
        force_co0[0] = 1'b0;

        // Flush in LOAD of the last byte with res_valid held, clearing the sticky err
        q[0] = 16'hCAFE; r[0] = 16'hBEEF;
        tin  = '{R, B, B, B, B, B, B, B, RF, R, B, B, B, B, B, B, B, B, B, B, Z};
        texp = '{8'h81, 8'h45, 8'h15, 8'h2D, 8'h15, 8'h2D, 8'h15, 8'h2D, 8'h45, 8'h80,
                 8'h44, 8'h14, 8'h2C, 8'h14, 8'h2C, 8'h14, 8'h2C, 8'h14, 8'h2C, 8'h06, 8'h80};
        run(0, "t5");

        // Flush beats res_valid in IDLE
        tin  = '{RF, Z, Z};
        texp = '{8'hC0, 8'h80, 8'h80};
        run(0, "flush_idle");

        // TIMEOUT=8 abort, then a normal frame with err still set
        q[1] = 16'h0F1E; r[1] = 16'h2D3C;
        tin  = '{R, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, R, B, B, B, B, B, B, B, B, B, B, Z};
        texp = '{8'h80, 8'h44, 8'h14, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h81,
                 8'h81, 8'h45, 8'h15, 8'h2D, 8'h15, 8'h2D, 8'h15, 8'h2D, 8'h15, 8'h2D, 8'h07, 8'h81};
        run(1, "t4");

        // Accept on the last allowed stall cycle wins over the timeout
        q[1] = 16'h5566; r[1] = 16'h7788;
        tin  = '{F, R, Z, Z, Z, Z, Z, Z, Z, Z, Z, B, B, B, B, B, B, B, B, Z};
        texp = '{8'hC1, 8'h80, 8'h44, 8'h14, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0C,
                 8'h2C, 8'h14, 8'h2C, 8'h14, 8'h2C, 8'h14, 8'h2C, 8'h06, 8'h80};
        run(1, "to_edge");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
